// File: rtl/ans_dec_arbiter.sv
// Round-robin arbiter sharing one ANS decoder among NUM_CH symbol streams.
// One transaction in flight; each result is routed back to its issuing channel.
module ans_dec_arbiter #(
    parameter int SYM_WIDTH = 8,
    parameter int NUM_CH    = 4,
    parameter int CH_W      = $clog2(NUM_CH)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_CH*SYM_WIDTH-1:0] ch_in,
    input  logic [NUM_CH-1:0]           ch_in_vld,
    output logic [NUM_CH-1:0]           ch_in_rdy,
    output logic [SYM_WIDTH-1:0]        ch_out,
    output logic [NUM_CH-1:0]           ch_out_vld,
    input  logic [NUM_CH-1:0]           ch_out_rdy,
    output logic [SYM_WIDTH-1:0]        dec_in,
    output logic                        dec_in_vld,
    input  logic                        dec_in_rdy,
    input  logic [SYM_WIDTH-1:0]        dec_out,
    input  logic                        dec_out_vld,
    output logic                        dec_out_rdy,
    output logic [CH_W-1:0]             owner,
    output logic                        busy
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } state_e;

    state_e               state_q, state_d;
    logic [CH_W-1:0]      ptr_q, ptr_d;
    logic [CH_W-1:0]      owner_q, owner_d;
    logic [SYM_WIDTH-1:0] dec_in_q, dec_in_d;
    logic                 dec_in_vld_q, dec_in_vld_d;

    logic                 hi_found, lo_found;
    logic [CH_W-1:0]      hi_idx, lo_idx, gnt;
    logic                 gnt_any;

    // Lowest requester at or above ptr wins; otherwise wrap to the lowest one.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch_in_vld[c] && !lo_found) begin
                lo_found = 1'b1;
                lo_idx   = CH_W'(c);
            end
            if (ch_in_vld[c] && !hi_found && c >= int'(ptr_q)) begin
                hi_found = 1'b1;
                hi_idx   = CH_W'(c);
            end
        end
        gnt_any = lo_found;
        gnt     = hi_found ? hi_idx : lo_idx;
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        owner_d      = owner_q;
        dec_in_d     = dec_in_q;
        dec_in_vld_d = dec_in_vld_q;
        ch_in_rdy    = '0;
        ch_out_vld   = '0;
        dec_out_rdy  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (gnt_any) begin
                    ch_in_rdy[gnt] = 1'b1;
                    dec_in_d       = ch_in[int'(gnt)*SYM_WIDTH +: SYM_WIDTH];
                    dec_in_vld_d   = 1'b1;
                    owner_d        = gnt;
                    state_d        = ISSUE;
                end
            end
            ISSUE: begin
                if (dec_in_rdy) begin
                    dec_in_vld_d = 1'b0;
                    state_d      = WAIT;
                end
            end
            WAIT: begin
                ch_out_vld[owner_q] = dec_out_vld;
                dec_out_rdy         = ch_out_rdy[owner_q];
                if (dec_out_vld && ch_out_rdy[owner_q]) begin
                    ptr_d   = (owner_q == CH_W'(NUM_CH - 1)) ? '0
                                                             : owner_q + 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            owner_q      <= '0;
            dec_in_q     <= '0;
            dec_in_vld_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            owner_q      <= owner_d;
            dec_in_q     <= dec_in_d;
            dec_in_vld_q <= dec_in_vld_d;
        end
    end

    assign ch_out     = dec_out;
    assign dec_in     = dec_in_q;
    assign dec_in_vld = dec_in_vld_q;
    assign owner      = owner_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_ans_dec_arbiter.sv
// Random-stimulus bench for ans_dec_arbiter with a transaction-level model
// and a toy decoder (XOR key) standing in for the real datapath.
module tb_ans_dec_arbiter;

    localparam int SW = 8;
    localparam int N  = 4;
    localparam int CW = 2;
    localparam logic [SW-1:0] KEY = 8'h3C;
    localparam int IDEAL_CYC = 40;
    localparam int RUN_CYC   = 3000;

    logic              clk;
    logic              rst_n;
    logic [N*SW-1:0]   ch_in;
    logic [N-1:0]      ch_in_vld;
    logic [N-1:0]      ch_in_rdy;
    logic [SW-1:0]     ch_out;
    logic [N-1:0]      ch_out_vld;
    logic [N-1:0]      ch_out_rdy;
    logic [SW-1:0]     dec_in;
    logic              dec_in_vld;
    logic              dec_in_rdy;
    logic [SW-1:0]     dec_out;
    logic              dec_out_vld;
    logic              dec_out_rdy;
    logic [CW-1:0]     owner;
    logic              busy;

    ans_dec_arbiter #(.SYM_WIDTH(SW), .NUM_CH(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ch_in      (ch_in),
        .ch_in_vld  (ch_in_vld),
        .ch_in_rdy  (ch_in_rdy),
        .ch_out     (ch_out),
        .ch_out_vld (ch_out_vld),
        .ch_out_rdy (ch_out_rdy),
        .dec_in     (dec_in),
        .dec_in_vld (dec_in_vld),
        .dec_in_rdy (dec_in_rdy),
        .dec_out    (dec_out),
        .dec_out_vld(dec_out_vld),
        .dec_out_rdy(dec_out_rdy),
        .owner      (owner),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Environment: channel sources and a toy decoder
    logic [SW-1:0] src_sym [N];
    logic [N-1:0]  src_vld;
    logic          dq_full;
    logic [SW-1:0] dq_buf;
    int            dq_lat;

    // Reference model: one outstanding transaction, rotating priority pointer
    bit            m_busy, m_sent;
    int            m_owner, m_ptr;
    logic [SW-1:0] m_sym;

    int            cyc, last_del, g, n_rst;
    bit            ideal;
    logic [N-1:0]  acc_src;
    bit            dec_take, dec_give, do_grant, do_send, do_done;
    logic [SW-1:0] take_val;

    function automatic int rr_pick(input int ptr, input logic [N-1:0] v);
        for (int k = 0; k < N; k++)
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction

    task automatic drive();
        for (int c = 0; c < N; c++) ch_in[c*SW +: SW] = src_sym[c];
        ch_in_vld = src_vld;
        if (dq_full) begin
            dec_out_vld = (dq_lat == 0);
            dec_out     = dq_buf ^ KEY;
        end else if (!ideal && $urandom_range(0, 3) == 0) begin
            dec_out_vld = 1'b1;
            dec_out     = SW'($urandom);
        end else begin
            dec_out_vld = 1'b0;
            dec_out     = '0;
        end
        for (int c = 0; c < N; c++)
            ch_out_rdy[c] = ideal ? 1'b1 : ($urandom_range(0, 9) < 7);
        dec_in_rdy = ideal ? 1'b1 : ($urandom_range(0, 9) < 6);
    endtask

    initial begin
        rst_n = 1'b0;
        ideal = 1'b1;
        src_vld = '0;
        for (int c = 0; c < N; c++) src_sym[c] = SW'($urandom);
        dq_full = 1'b0; dq_buf = '0; dq_lat = 0;
        m_busy = 0; m_sent = 0; m_owner = 0; m_ptr = 0; m_sym = '0;
        last_del = -1; n_rst = 0;
        drive();
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_owner", owner, 0);
        chk("rst_dec_in", dec_in, 0);
        chk("rst_dec_in_vld", dec_in_vld, 0);
        chk("rst_ch_out_vld", ch_out_vld, 0);
        chk("rst_dec_out_rdy", dec_out_rdy, 0);
        chk("rst_ch_in_rdy", ch_in_rdy, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n   = 1'b1;
        src_vld = '1;
        drive();

        for (cyc = 0; cyc < RUN_CYC; cyc++) begin
            ideal = (cyc < IDEAL_CYC);
            if (cyc == IDEAL_CYC) last_del = -1;
            @(negedge clk);
            chk("busy", busy, m_busy);
            chk("owner", owner, m_owner);
            do_grant = 0; do_send = 0; do_done = 0;
            if (!m_busy) begin
                g = rr_pick(m_ptr, src_vld);
                chk("ch_in_rdy", ch_in_rdy, (g >= 0) ? (1 << g) : 0);
                chk("dec_in_vld_idle", dec_in_vld, 0);
                chk("ch_out_vld_idle", ch_out_vld, 0);
                chk("dec_out_rdy_idle", dec_out_rdy, 0);
                do_grant = (g >= 0);
            end else if (!m_sent) begin
                chk("ch_in_rdy_issue", ch_in_rdy, 0);
                chk("dec_in_vld_issue", dec_in_vld, 1);
                chk("dec_in_issue", dec_in, m_sym);
                chk("ch_out_vld_issue", ch_out_vld, 0);
                chk("dec_out_rdy_issue", dec_out_rdy, 0);
                do_send = dec_in_rdy;
            end else begin
                chk("ch_in_rdy_wait", ch_in_rdy, 0);
                chk("dec_in_vld_wait", dec_in_vld, 0);
                chk("ch_out_vld", ch_out_vld, dec_out_vld ? (1 << m_owner) : 0);
                chk("dec_out_rdy", dec_out_rdy, ch_out_rdy[m_owner]);
                if (dec_out_vld) chk("ch_out", ch_out, m_sym ^ KEY);
                do_done = dec_out_vld && ch_out_rdy[m_owner];
                if (do_done && ideal) begin
                    if (last_del >= 0) chk("period", cyc - last_del, 3);
                    last_del = cyc;
                end
            end
            acc_src  = ch_in_rdy & ch_in_vld;
            dec_take = dec_in_vld && dec_in_rdy;
            take_val = dec_in;
            dec_give = dq_full && dec_out_vld && dec_out_rdy;

            if (!ideal && m_busy && m_sent && n_rst < 6 &&
                $urandom_range(0, 30) == 0) begin
                #2 rst_n = 1'b0;
                #1;
                chk("mid_rst_busy", busy, 0);
                chk("mid_rst_owner", owner, 0);
                chk("mid_rst_dec_in", dec_in, 0);
                chk("mid_rst_dec_in_vld", dec_in_vld, 0);
                chk("mid_rst_ch_out_vld", ch_out_vld, 0);
                chk("mid_rst_dec_out_rdy", dec_out_rdy, 0);
                n_rst++;
                m_busy = 0; m_sent = 0; m_owner = 0; m_ptr = 0;
                dq_full = 1'b0; dq_lat = 0;
                @(posedge clk);
                #1;
                rst_n = 1'b1;
                drive();
                continue;
            end

            @(posedge clk);
            #1;
            if (do_grant) begin
                m_busy  = 1;
                m_sent  = 0;
                m_owner = g;
                m_sym   = src_sym[g];
            end else if (do_send) begin
                m_sent = 1;
            end else if (do_done) begin
                m_busy = 0;
                m_ptr  = (m_owner + 1) % N;
            end
            for (int c = 0; c < N; c++) begin
                if (acc_src[c]) begin
                    src_sym[c] = SW'($urandom);
                    src_vld[c] = ideal ? 1'b1 : 1'($urandom_range(0, 1));
                end else if (!src_vld[c] && $urandom_range(0, 2) == 0) begin
                    src_vld[c] = 1'b1;
                end
            end
            if (dec_give) begin
                dq_full = 1'b0;
            end else if (dec_take) begin
                dq_full = 1'b1;
                dq_buf  = take_val;
                dq_lat  = ideal ? 0 : $urandom_range(0, 3);
            end else if (dq_full && dq_lat > 0) begin
                dq_lat--;
            end
            drive();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
